// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   XLEN         : datapath width of results and PCs
//   REG_BIT      : architectural register index width
//   issue_type_e : how an instruction retires (register write, store,
//                  branch, or already complete at issue)
package rob_pkg;

  localparam int XLEN    = 32;
  localparam int REG_BIT = 5;

  typedef enum logic [1:0] {
    ITYPE_REG    = 2'd0,  // writes rd once its result arrives on writeback
    ITYPE_STORE  = 2'd1,  // memory write performed by the LSB at retirement
    ITYPE_BRANCH = 2'd2,  // resolved next PC arrives on writeback
    ITYPE_DONE   = 2'd3   // LUI/AUIPC/JAL/JALR: result known at issue
  } issue_type_e;

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup for one reorder-buffer tag.
//   tag          : entry being looked up
//   stored_done  : done bit of that entry
//   stored_value : stored value of that entry
//   wb_valid/wb_tag/wb_value : packed writeback channels (bypass sources)
//   ready        : value available (stored, or arriving this cycle)
//   value        : the value, 0 when not ready
// Priority: stored value, then channel 0, 1, ... NUM_WB-1.
module rob_lookup
  import rob_pkg::*;
#(
  parameter int IDX    = 3,
  parameter int NUM_WB = 2
) (
  input  logic [IDX-1:0]         tag,
  input  logic                   stored_done,
  input  logic [XLEN-1:0]        stored_value,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IDX-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0] wb_value,
  output logic                   ready,
  output logic [XLEN-1:0]        value
);

  always_comb begin
    ready = stored_done;
    value = stored_done ? stored_value : '0;
    // First matching channel wins; later channels only fill in if nothing
    // earlier has supplied a value.
    for (int k = 0; k < NUM_WB; k++) begin
      if (!ready && wb_valid[k] && (wb_tag[k*IDX +: IDX] == tag)) begin
        ready = 1'b1;
        value = wb_value[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/reorder_buf.sv
// Circular reorder buffer: in-order issue, out-of-order writeback,
// in-order commit with branch-mispredict flush.
//   clk_in, rst_in, rdy_in : clock, sync active-high reset, global pause
//   issue_*                : allocate tail entry; issue_tag returns its index
//   wb_*                   : NUM_WB packed writeback channels
//   q1_*, q2_*             : operand lookup ports (with writeback bypass)
//   commit_*               : head retirement (register write / store)
//   flush, flush_pc        : mispredicted branch at head; redirect fetch
//   full, empty, count     : occupancy, all derived from registers
module reorder_buf
  import rob_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int NUM_WB = 2,
  localparam int IDX    = $clog2(DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [1:0]             issue_type,
  input  logic [REG_BIT-1:0]     issue_rd,
  input  logic [XLEN-1:0]        issue_value,
  output logic [IDX-1:0]         issue_tag,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IDX-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0] wb_value,
  input  logic [IDX-1:0]         q1_tag,
  input  logic [IDX-1:0]         q2_tag,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [XLEN-1:0]        q1_value,
  output logic [XLEN-1:0]        q2_value,
  output logic                   commit_valid,
  output logic [REG_BIT-1:0]     commit_rd,
  output logic [IDX-1:0]         commit_tag,
  output logic [XLEN-1:0]        commit_value,
  output logic                   commit_store,
  output logic                   flush,
  output logic [XLEN-1:0]        flush_pc,
  output logic                   full,
  output logic                   empty,
  output logic [IDX:0]           count
);

  logic [DEPTH-1:0]   busy_reg, done_reg;
  issue_type_e        type_reg  [DEPTH];
  logic [REG_BIT-1:0] rd_reg    [DEPTH];
  logic [XLEN-1:0]    value_reg [DEPTH];  // result, or resolved PC for branches
  logic [XLEN-1:0]    pred_reg  [DEPTH];  // predicted next PC for branches
  logic [IDX-1:0]     head_reg, tail_reg;
  logic [IDX:0]       count_reg, count_next;

  logic [IDX-1:0]  wb_tag_arr [NUM_WB];
  logic [XLEN-1:0] wb_val_arr [NUM_WB];

  for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb
    assign wb_tag_arr[gi] = wb_tag[gi*IDX +: IDX];
    assign wb_val_arr[gi] = wb_value[gi*XLEN +: XLEN];
  end

  logic        issue_fire, commit_fire, mispredict;
  issue_type_e head_type;

  assign full        = (count_reg == (IDX+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign count       = count_reg;
  assign issue_ready = !full;
  assign issue_tag   = tail_reg;
  assign issue_fire  = rdy_in && issue_valid && issue_ready;

  assign head_type   = type_reg[head_reg];
  assign commit_fire = rdy_in && busy_reg[head_reg] && done_reg[head_reg];
  assign mispredict  = commit_fire && (head_type == ITYPE_BRANCH) &&
                       (value_reg[head_reg] != pred_reg[head_reg]);

  assign commit_valid = commit_fire && (rd_reg[head_reg] != '0) &&
                        ((head_type == ITYPE_REG) || (head_type == ITYPE_DONE));
  assign commit_store = commit_fire && (head_type == ITYPE_STORE);
  assign commit_rd    = rd_reg[head_reg];
  assign commit_tag   = head_reg;
  assign commit_value = value_reg[head_reg];
  assign flush        = mispredict;
  assign flush_pc     = value_reg[head_reg];

  assign count_next = count_reg + (IDX+1)'(issue_fire) - (IDX+1)'(commit_fire);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_reg  <= '0;
      done_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        // Everything younger than the branch is wrong-path: drop it all,
        // including anything issuing or writing back this cycle.
        busy_reg  <= '0;
        done_reg  <= '0;
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        // Walk channels high to low so the lowest channel's write lands last.
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (wb_valid[k]) begin
            assert (busy_reg[wb_tag_arr[k]] && !done_reg[wb_tag_arr[k]]);
            if (busy_reg[wb_tag_arr[k]] && !done_reg[wb_tag_arr[k]]) begin
              done_reg[wb_tag_arr[k]]  <= 1'b1;
              value_reg[wb_tag_arr[k]] <= wb_val_arr[k];
            end
          end
        end
        // Issue targets a free slot, so it never collides with a writeback
        // (ignored on non-busy entries) or with the committing head.
        if (issue_fire) begin
          busy_reg[tail_reg]  <= 1'b1;
          done_reg[tail_reg]  <= (issue_type_e'(issue_type) == ITYPE_DONE);
          type_reg[tail_reg]  <= issue_type_e'(issue_type);
          rd_reg[tail_reg]    <= issue_rd;
          value_reg[tail_reg] <= issue_value;
          pred_reg[tail_reg]  <= issue_value;
          tail_reg            <= tail_reg + IDX'(1);
        end
        if (commit_fire) begin
          busy_reg[head_reg] <= 1'b0;
          done_reg[head_reg] <= 1'b0;
          head_reg           <= head_reg + IDX'(1);
        end
        count_reg <= count_next;
      end
    end
  end

  logic [IDX-1:0]  q_tag   [2];
  logic            q_ready [2];
  logic [XLEN-1:0] q_value [2];

  assign q_tag[0] = q1_tag;
  assign q_tag[1] = q2_tag;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    rob_lookup #(
      .IDX    (IDX),
      .NUM_WB (NUM_WB)
    ) u_lookup (
      .tag          (q_tag[gi]),
      .stored_done  (done_reg[q_tag[gi]]),
      .stored_value (value_reg[q_tag[gi]]),
      .wb_valid     (wb_valid),
      .wb_tag       (wb_tag),
      .wb_value     (wb_value),
      .ready        (q_ready[gi]),
      .value        (q_value[gi])
    );
  end

  assign q1_ready = q_ready[0];
  assign q2_ready = q_ready[1];
  assign q1_value = q_value[0];
  assign q2_value = q_value[1];

endmodule

// File: tb/tb_reorder_buf.sv
// Bench for reorder_buf: directed vector table (fill, out-of-order
// writeback, wrap and drain), hand sequences for flush, bypass priority,
// pause and latency, then randomized traffic against a queue-based model.
module tb_reorder_buf;
  import rob_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_WB = 2;
  localparam int IDX    = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in, rdy_in, issue_valid, issue_ready;
  logic [1:0]        issue_type;
  logic [4:0]        issue_rd;
  logic [31:0]       issue_value;
  logic [IDX-1:0]    issue_tag;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX-1:0]  wb_tag;
  logic [NUM_WB*32-1:0]   wb_value;
  logic [IDX-1:0]    q1_tag, q2_tag;
  logic              q1_ready, q2_ready;
  logic [31:0]       q1_value, q2_value;
  logic              commit_valid, commit_store, flush, full, empty;
  logic [4:0]        commit_rd;
  logic [IDX-1:0]    commit_tag;
  logic [31:0]       commit_value, flush_pc;
  logic [IDX:0]      count;

  reorder_buf #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_value(issue_value), .issue_tag(issue_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_value(commit_value),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc),
    .full(full), .empty(empty), .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in      = 1'b1;
    issue_valid = 1'b0;
    issue_type  = 2'd0;
    issue_rd    = 5'd0;
    issue_value = 32'd0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_value    = '0;
    q1_tag      = '0;
    q2_tag      = '0;
  endtask

  task automatic set_wb(input int ch, input logic [2:0] t, input logic [31:0] v);
    wb_valid[ch]        = 1'b1;
    wb_tag[ch*IDX +: IDX] = t;
    wb_value[ch*32 +: 32] = v;
  endtask

  task automatic set_issue(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] v);
    issue_valid = 1'b1;
    issue_type  = ty;
    issue_rd    = rd;
    issue_value = v;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          iv;
    logic [1:0]  ity;
    logic [4:0]  ird;
    logic [31:0] ival;
    bit          wbv;
    logic [2:0]  wbt;
    logic [31:0] wbd;
    int          e_itag;
    int          e_cnt;
    bit          e_cv;
    int          e_ctag;
    int          e_crd;
    logic [31:0] e_cval;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit iv, input int ity, input int ird, input logic [31:0] ival,
                              input bit wbv, input int wbt, input logic [31:0] wbd,
                              input int e_itag, input int e_cnt, input bit e_cv,
                              input int e_ctag, input int e_crd, input logic [31:0] e_cval);
    vec_t v;
    v.iv = iv; v.ity = 2'(ity); v.ird = 5'(ird); v.ival = ival;
    v.wbv = wbv; v.wbt = 3'(wbt); v.wbd = wbd;
    v.e_itag = e_itag; v.e_cnt = e_cnt; v.e_cv = e_cv;
    v.e_ctag = e_ctag; v.e_crd = e_crd; v.e_cval = e_cval;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [2:0]  tag;
    bit          done;
    logic [31:0] val;
    logic [31:0] pred;
  } ent_t;

  ent_t mq[$];   // in-flight instructions, oldest first
  int   mtail;   // next tag to hand out

  function automatic void model_lookup(input logic [2:0] t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[j]) begin
      if (mq[j].tag == t && mq[j].done) begin
        r = 1'b1;
        v = mq[j].val;
      end
    end
    for (int k = 0; k < NUM_WB; k++) begin
      if (!r && wb_valid[k] && wb_tag[k*IDX +: IDX] == t) begin
        r = 1'b1;
        v = wb_value[k*32 +: 32];
      end
    end
  endfunction

  task automatic rnd_cycle(input int cyc);
    int  r, e_cnt;
    bit  hc, e_cv, e_st, e_fl, lr;
    logic [31:0] lv;
    int  cand[$];
    bit [7:0] hit;

    idle_inputs();
    rdy_in = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 1) == 1) begin
      r = $urandom_range(0, 9);
      set_issue((r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd3 : 2'd2,
                5'($urandom_range(0, 31)), $urandom);
    end
    for (int ch = 0; ch < NUM_WB; ch++) begin
      if ($urandom_range(0, 1) == 1) begin
        cand.delete();
        foreach (mq[j]) if (!mq[j].done) cand.push_back(j);
        if (cand.size() > 0) begin
          r = cand[$urandom_range(0, cand.size() - 1)];
          if (mq[r].ty == 2'd2)
            set_wb(ch, mq[r].tag, ($urandom_range(0, 3) == 0) ? (mq[r].pred ^ 32'h10) : mq[r].pred);
          else
            set_wb(ch, mq[r].tag, $urandom);
        end
      end
    end
    q1_tag = 3'($urandom_range(0, 7));
    q2_tag = 3'($urandom_range(0, 7));
    #1;

    e_cnt = mq.size();
    hc    = rdy_in && (e_cnt > 0) && mq[0].done;
    e_cv  = hc && (mq[0].ty == 2'd0 || mq[0].ty == 2'd3) && (mq[0].rd != 5'd0);
    e_st  = hc && (mq[0].ty == 2'd1);
    e_fl  = hc && (mq[0].ty == 2'd2) && (mq[0].val != mq[0].pred);
    chk($sformatf("rnd%0d count", cyc), 32'(count), 32'(e_cnt));
    chk($sformatf("rnd%0d issue_ready", cyc), 32'(issue_ready), 32'(e_cnt < DEPTH));
    chk($sformatf("rnd%0d full", cyc), 32'(full), 32'(e_cnt == DEPTH));
    chk($sformatf("rnd%0d empty", cyc), 32'(empty), 32'(e_cnt == 0));
    chk($sformatf("rnd%0d issue_tag", cyc), 32'(issue_tag), 32'(mtail));
    chk($sformatf("rnd%0d commit_valid", cyc), 32'(commit_valid), 32'(e_cv));
    chk($sformatf("rnd%0d commit_store", cyc), 32'(commit_store), 32'(e_st));
    chk($sformatf("rnd%0d flush", cyc), 32'(flush), 32'(e_fl));
    if (e_cv || e_st) chk($sformatf("rnd%0d commit_tag", cyc), 32'(commit_tag), 32'(mq[0].tag));
    if (e_cv) begin
      chk($sformatf("rnd%0d commit_rd", cyc), 32'(commit_rd), 32'(mq[0].rd));
      chk($sformatf("rnd%0d commit_value", cyc), commit_value, mq[0].val);
    end
    if (e_fl) chk($sformatf("rnd%0d flush_pc", cyc), flush_pc, mq[0].val);
    model_lookup(q1_tag, lr, lv);
    chk($sformatf("rnd%0d q1_ready", cyc), 32'(q1_ready), 32'(lr));
    chk($sformatf("rnd%0d q1_value", cyc), q1_value, lv);
    model_lookup(q2_tag, lr, lv);
    chk($sformatf("rnd%0d q2_ready", cyc), 32'(q2_ready), 32'(lr));
    chk($sformatf("rnd%0d q2_value", cyc), q2_value, lv);

    // Advance the model by one clock edge.
    if (rdy_in) begin
      if (e_fl) begin
        mq.delete();
        mtail = 0;
      end else begin
        hit = '0;
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_valid[k] && !hit[wb_tag[k*IDX +: IDX]]) begin
            hit[wb_tag[k*IDX +: IDX]] = 1'b1;
            foreach (mq[j]) begin
              if (mq[j].tag == wb_tag[k*IDX +: IDX] && !mq[j].done) begin
                mq[j].done = 1'b1;
                mq[j].val  = wb_value[k*32 +: 32];
              end
            end
          end
        end
        if (hc) void'(mq.pop_front());
        if (issue_valid && e_cnt < DEPTH) begin
          ent_t e;
          e.ty = issue_type; e.rd = issue_rd; e.tag = 3'(mtail);
          e.done = (issue_type == 2'd3); e.val = issue_value; e.pred = issue_value;
          mq.push_back(e);
          mtail = (mtail + 1) % DEPTH;
        end
      end
    end
    tick();
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    chk("reset commit_valid", 32'(commit_valid), 32'd0);
    chk("reset commit_store", 32'(commit_store), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset issue_ready", 32'(issue_ready), 32'd1);
    chk("reset count", 32'(count), 32'd0);
    chk("reset issue_tag", 32'(issue_tag), 32'd0);

    // Fill to full, out-of-order writeback, wrap, drain.
    for (int i = 0; i < 8; i++) vq.push_back(mk(1, 0, i + 1, 0, 0, 0, 0, i, i, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 9, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0));             // blocked while full
    vq.push_back(mk(0, 0, 0, 0, 1, 2, 32'h200, 0, 8, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h100, 0, 8, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 32'h101, 0, 8, 1, 0, 1, 32'h100));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 2, 32'h101));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 2, 3, 32'h200));
    vq.push_back(mk(0, 0, 0, 0, 1, 3, 32'h300, 0, 5, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 4, 32'h400, 0, 5, 1, 3, 4, 32'h300));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 4, 5, 32'h400));
    for (int j = 0; j < 5; j++) vq.push_back(mk(1, 3, 10 + j, 32'h500 + 32'(j), 0, 0, 0, j, 3 + j, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 20, 0, 1, 5, 32'h605, 5, 8, 0, 0, 0, 0));     // blocked while full
    vq.push_back(mk(1, 0, 20, 0, 1, 6, 32'h606, 5, 8, 1, 5, 6, 32'h605)); // blocked despite commit
    vq.push_back(mk(0, 0, 0, 0, 1, 7, 32'h607, 5, 7, 1, 6, 7, 32'h606));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 6, 1, 7, 8, 32'h607));
    for (int j = 0; j < 5; j++) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 5 - j, 1, j, 10 + j, 32'h500 + 32'(j)));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      idle_inputs();
      if (vq[i].iv) set_issue(vq[i].ity, vq[i].ird, vq[i].ival);
      if (vq[i].wbv) set_wb(0, vq[i].wbt, vq[i].wbd);
      #1;
      chk($sformatf("vec%0d issue_tag", i), 32'(issue_tag), 32'(vq[i].e_itag));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vq[i].e_cnt));
      chk($sformatf("vec%0d issue_ready", i), 32'(issue_ready), 32'(vq[i].e_cnt != 8));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vq[i].e_cnt == 8));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vq[i].e_cnt == 0));
      chk($sformatf("vec%0d commit_valid", i), 32'(commit_valid), 32'(vq[i].e_cv));
      if (vq[i].e_cv) begin
        chk($sformatf("vec%0d commit_tag", i), 32'(commit_tag), 32'(vq[i].e_ctag));
        chk($sformatf("vec%0d commit_rd", i), 32'(commit_rd), 32'(vq[i].e_crd));
        chk($sformatf("vec%0d commit_value", i), commit_value, vq[i].e_cval);
      end
      tick();
    end

    // Done-at-issue commits the next cycle; rd=0 retires silently.
    do_reset();
    set_issue(2'd3, 5'd9, 32'h55);
    #1 chk("t3 commit same cycle", 32'(commit_valid), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("t3 commit_valid", 32'(commit_valid), 32'd1);
    chk("t3 commit_value", commit_value, 32'h55);
    chk("t3 commit_rd", 32'(commit_rd), 32'd9);
    tick();
    set_issue(2'd3, 5'd0, 32'h66);
    tick();
    idle_inputs();
    #1;
    chk("rd0 commit_valid", 32'(commit_valid), 32'd0);
    chk("rd0 count", 32'(count), 32'd1);
    tick();
    chk("rd0 empty after", 32'(empty), 32'd1);

    // Branch mispredict at head, with same-cycle issue and writeback dropped.
    do_reset();
    set_issue(2'd2, 5'd0, 32'h1004);
    tick();
    set_issue(2'd0, 5'd5, 32'd0);
    tick();
    idle_inputs();
    set_wb(0, 3'd0, 32'h2000);
    #1 chk("br flush before done", 32'(flush), 32'd0);
    tick();
    idle_inputs();
    set_issue(2'd3, 5'd7, 32'h77);
    set_wb(0, 3'd1, 32'h1234);
    #1;
    chk("br flush", 32'(flush), 32'd1);
    chk("br flush_pc", flush_pc, 32'h2000);
    chk("br commit_valid", 32'(commit_valid), 32'd0);
    chk("br commit_store", 32'(commit_store), 32'd0);
    tick();
    idle_inputs();
    q1_tag = 3'd1;
    #1;
    chk("br flush after", 32'(flush), 32'd0);
    chk("br empty after", 32'(empty), 32'd1);
    chk("br count after", 32'(count), 32'd0);
    chk("br issue_tag after", 32'(issue_tag), 32'd0);
    chk("br q1_ready cleared", 32'(q1_ready), 32'd0);
    // Correctly predicted branch retires without flush.
    set_issue(2'd2, 5'd0, 32'h1004);
    tick();
    idle_inputs();
    set_wb(0, 3'd0, 32'h1004);
    tick();
    idle_inputs();
    #1;
    chk("br ok flush", 32'(flush), 32'd0);
    chk("br ok commit_valid", 32'(commit_valid), 32'd0);
    chk("br ok count", 32'(count), 32'd1);
    tick();
    chk("br ok count after", 32'(count), 32'd0);

    // Two channels to one tag: channel 0 wins for bypass and storage.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_issue(2'd0, 5'(i + 1), 32'd0);
      tick();
    end
    idle_inputs();
    set_wb(0, 3'd3, 32'hAA);
    set_wb(1, 3'd3, 32'hBB);
    q1_tag = 3'd3;
    q2_tag = 3'd2;
    #1;
    chk("dual q1_ready", 32'(q1_ready), 32'd1);
    chk("dual q1_value", q1_value, 32'hAA);
    chk("dual q2_ready", 32'(q2_ready), 32'd0);
    chk("dual q2_value", q2_value, 32'd0);
    tick();
    idle_inputs();
    q1_tag = 3'd3;
    #1;
    chk("dual stored ready", 32'(q1_ready), 32'd1);
    chk("dual stored value", q1_value, 32'hAA);

    // Pause with a done head: nothing moves until rdy_in returns.
    set_wb(0, 3'd0, 32'h11);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      set_issue(2'd0, 5'd9, 32'd0);
      #1;
      chk($sformatf("pause%0d commit_valid", i), 32'(commit_valid), 32'd0);
      chk($sformatf("pause%0d count", i), 32'(count), 32'd4);
      chk($sformatf("pause%0d issue_tag", i), 32'(issue_tag), 32'd4);
      tick();
    end
    idle_inputs();
    #1;
    chk("resume commit_valid", 32'(commit_valid), 32'd1);
    chk("resume commit_tag", 32'(commit_tag), 32'd0);
    chk("resume commit_value", commit_value, 32'h11);
    tick();
    chk("resume count after", 32'(count), 32'd3);

    // Reset wins even while paused.
    rst_in = 1'b1;
    rdy_in = 1'b0;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    #1;
    chk("paused reset count", 32'(count), 32'd0);
    chk("paused reset empty", 32'(empty), 32'd1);

    // Randomized traffic against the queue model.
    do_reset();
    mq.delete();
    mtail = 0;
    for (int c = 0; c < 600; c++) rnd_cycle(c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter DEPTH, 8, number of entries; SHALL be a power of two, at least 2; IDX = log2(DEPTH).
REQ-002 Parameter NUM_WB, 2, number of writeback broadcast channels; SHALL be at least 1.
REQ-003 clk_in  in  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst_in  in  1  reset, synchronous, active-high.
REQ-005 rdy_in  in  1  pause; when low, no state SHALL change.
REQ-006 issue_valid  in  1  decoder presents an instruction.
REQ-007 issue_ready  out  1  entry available; equals !full.
REQ-008 issue_type  in  2  0 = reg-writing, 1 = store, 2 = branch, 3 = done-at-issue (LUI/AUIPC/JAL/JALR).
REQ-009 issue_rd  in  5  destination register.
REQ-010 issue_value  in  32  result for type 3, predicted next PC for type 2, else ignored.
REQ-011 issue_tag  out  IDX  tail index given to the issuing instruction.
REQ-012 wb_valid / wb_tag / wb_value  in  NUM_WB / NUM_WB*IDX / NUM_WB*32  packed writeback channels.
REQ-013 q1_tag, q2_tag  in  IDX  operand lookup tags.
REQ-014 q1_ready, q2_ready  out  1  looked-up entry has a value.
REQ-015 q1_value, q2_value  out  32  looked-up value.
REQ-016 commit_valid / commit_rd / commit_tag / commit_value  out  1/5/IDX/32  register commit.
REQ-017 commit_store  out  1  head store retires; the LSB performs the memory write.
REQ-018 flush / flush_pc  out  1/32  branch mispredict; redirect the PC.
REQ-019 full, empty  out  1  occupancy flags; count  out  IDX+1  occupied entries.

Function
REQ-020 full SHALL be count==DEPTH and empty SHALL be count==0, both derived from registers only; issue_ready SHALL NOT depend combinationally on issue_valid or on commit.
REQ-021 An issue fires when rdy_in && issue_valid && issue_ready; the entry at tail becomes busy, and tail advances modulo DEPTH.
REQ-022 A type-3 entry SHALL be done at issue with value issue_value; all other types become done only via writeback.
REQ-023 For each wb_valid[k], the entry at wb_tag[k] SHALL become done with value wb_value[k]; on equal tags, the lowest k wins.
REQ-024 A writeback to a non-busy or already-done entry SHALL be ignored and SHALL fire a simulation-only assertion.
REQ-025 Commit occurs when the head entry is busy and done, at most one per cycle.
  - Commit outputs are combinational from the head entry and gated by rdy_in.
  - head advances on the same edge.
REQ-026 commit_valid=1 for types 0 and 3 with rd!=0; commit_store=1 for type 1; neither output asserts for type 2.
REQ-027 For a type-2 commit, when the resolved next PC (wb value) != the stored predicted PC:
  - flush=1 and flush_pc=resolved PC.
  - On the next edge, all entries are cleared; head=tail=count=0.
  - A same-cycle issue or writeback is discarded.
REQ-028 Issue and commit in the same cycle SHALL leave count unchanged; issue while full is blocked even if a commit happens in that cycle.
REQ-029 Lookup: qN_ready = done[tag] || any matching wb_valid.
  - Value priority: stored value first, then wb channel 0..NUM_WB-1.
  - qN_value=0 when not ready.
REQ-030 Minimum latency: writeback in cycle N allows commit in cycle N+1; a type-3 entry issued in cycle N can commit in cycle N+1.
REQ-031 Pointers SHALL wrap DEPTH-1 -> 0 with no loss of entries, and SHALL support a full-ring fill and drain.

Reset
REQ-032 With rst_in high on a clock edge, all busy/done bits, head, tail and count SHALL become 0, regardless of rdy_in or flush.
REQ-033 After reset, the output values are: commit_valid=commit_store=flush=0, full=0, empty=1, issue_ready=1, count=0, issue_tag=0.

Structure
REQ-034 The shared package rob_pkg SHALL hold the issue_type encodings, XLEN=32 and REG_BIT=5; DEPTH and NUM_WB stay module parameters.
REQ-035 Sub-module rob_lookup (tag match plus priority mux over stored value and NUM_WB channels) SHALL be instantiated once per lookup port.

Verification
REQ-036 Reset, then 8 type-0 issues with no writeback -> full=1, issue_ready=0, count=8, issue_tag sequence 0..7.
REQ-037 Writebacks to tags 2, 0, 1 in consecutive cycles -> commits in tag order 0, 1, 2 only from the third cycle onward, and commit_value matches each tag.
REQ-038 Wrap test: commit 5 entries, issue 5 more -> issue_tags 0..4 reused, and count stays within 8.
REQ-039 Branch at head with predicted 0x1004, wb value 0x2000 -> flush=1 and flush_pc=0x2000 for one cycle, then empty=1 with a same-cycle issue dropped.
REQ-040 wb ch0 and ch1 to tag 3 in one cycle (0xAA, 0xBB), with q1_tag=3 -> q1_ready=1 and q1_value=0xAA that cycle, and the stored value is 0xAA.
REQ-041 rdy_in low for 3 cycles with a done head -> no commit_valid and no pointer change; the commit occurs on the first cycle rdy_in returns high.
